// File: rtl/afe_config_pkg.sv
// rtl/afe_config_pkg.sv - shared state enum and command encodings for the AFE config sequencer
package afe_config_pkg;

  typedef enum logic [2:0] {
    IDLE, FETCH, LATCH, SHIFT, GAP, DELAY, NEXT, DONE
  } seq_state_t;

  localparam logic [23:0] CMD_END      = 24'hFFFFFF;
  localparam logic [7:0]  CMD_DELAY_OP = 8'hFE;
  localparam int          FRAME_BITS   = 24;

endpackage

// File: rtl/afe_spi_shifter.sv
// rtl/afe_spi_shifter.sv - 3-wire SPI frame serialiser, MSB first, sclk idles low
// AFE_READBACK_EN adds sdout capture on sclk rising edges into readback_data/readback_valid.
module afe_spi_shifter
  import afe_config_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [FRAME_BITS-1:0] data_in,
`ifdef AFE_READBACK_EN
  input  logic                  sdout,
  output logic [15:0]           readback_data,
  output logic                  readback_valid,
`endif
  output logic                  busy,
  output logic                  frame_done,
  output logic                  sclk,
  output logic                  sdata,
  output logic                  sen_n
);

  localparam int DIV_W = $clog2(CLK_DIV);

  logic [DIV_W-1:0]      div_cnt;
  logic [FRAME_BITS-1:0] shreg;
  logic [4:0]            fall_cnt;
  logic                  tick;

  assign tick       = busy && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign frame_done = tick && sclk && (fall_cnt == 5'(FRAME_BITS - 1));
  assign sdata      = shreg[FRAME_BITS-1];

  // The 24th falling edge toggles sclk back to 0 and releases sen_n in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy     <= 1'b0;
      sclk     <= 1'b0;
      sen_n    <= 1'b1;
      shreg    <= '0;
      div_cnt  <= '0;
      fall_cnt <= '0;
    end else if (load && !busy) begin
      busy     <= 1'b1;
      sclk     <= 1'b0;
      sen_n    <= 1'b0;
      shreg    <= data_in;
      div_cnt  <= '0;
      fall_cnt <= '0;
    end else if (busy) begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) begin
        sclk <= ~sclk;
        if (sclk) begin
          shreg    <= {shreg[FRAME_BITS-2:0], 1'b0};
          fall_cnt <= fall_cnt + 1'b1;
        end
        if (frame_done) begin
          busy  <= 1'b0;
          sen_n <= 1'b1;
        end
      end
    end
  end

`ifdef AFE_READBACK_EN
  logic [15:0] rb_shift;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rb_shift       <= '0;
      readback_data  <= '0;
      readback_valid <= 1'b0;
    end else begin
      readback_valid <= 1'b0;
      if (tick && !sclk) rb_shift <= {rb_shift[14:0], sdout};
      if (frame_done) begin
        readback_data  <= rb_shift;
        readback_valid <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/afe_config_sequencer.sv
// rtl/afe_config_sequencer.sv - walks the AFE command ROM and issues SPI writes/delays
// AFE_READBACK_EN adds afe_sdout input and readback_data/readback_valid outputs.
module afe_config_sequencer
  import afe_config_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int GAP_CYCLES  = 8,
  parameter int DELAY_SHIFT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [7:0]  rom_address,
  input  logic [23:0] rom_command,
  output logic        afe_sclk,
  output logic        afe_sdata,
  output logic        afe_sen_n,
`ifdef AFE_READBACK_EN
  input  logic        afe_sdout,
  output logic [15:0] readback_data,
  output logic        readback_valid,
`endif
  output logic        busy,
  output logic        done,
  output logic        overrun
);

  localparam int CNT_W = 16 + DELAY_SHIFT;

  seq_state_t       state, state_nx;
  logic [7:0]       addr_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             overrun_nx;
  logic             load;
  logic             spi_busy;
  logic             frame_done;

  afe_spi_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk            (clk),
    .reset          (reset),
    .load           (load),
    .data_in        (rom_command),
`ifdef AFE_READBACK_EN
    .sdout          (afe_sdout),
    .readback_data  (readback_data),
    .readback_valid (readback_valid),
`endif
    .busy           (spi_busy),
    .frame_done     (frame_done),
    .sclk           (afe_sclk),
    .sdata          (afe_sdata),
    .sen_n          (afe_sen_n)
  );

  always_comb begin
    state_nx   = state;
    addr_nx    = rom_address;
    cnt_nx     = cnt;
    overrun_nx = overrun;
    load       = 1'b0;
    case (state)
      IDLE: if (start) begin
        addr_nx    = '0;
        overrun_nx = 1'b0;
        state_nx   = FETCH;
      end
      FETCH: state_nx = LATCH;
      LATCH: begin
        if (rom_command == CMD_END) begin
          state_nx = DONE;
        end else if (rom_command[23:16] == CMD_DELAY_OP) begin
          cnt_nx   = CNT_W'(rom_command[15:0]) << DELAY_SHIFT;
          state_nx = (rom_command[15:0] == 16'd0) ? NEXT : DELAY;
        end else begin
          load     = 1'b1;
          state_nx = SHIFT;
        end
      end
      // An idle shifter also releases SHIFT so the walk can never stall here.
      SHIFT: if (frame_done || !spi_busy) begin
        cnt_nx   = CNT_W'(GAP_CYCLES);
        state_nx = GAP;
      end
      GAP, DELAY: begin
        cnt_nx = cnt - 1'b1;
        if (cnt <= CNT_W'(1)) state_nx = NEXT;
      end
      NEXT: begin
        if (rom_address == 8'hFF) begin
          overrun_nx = 1'b1;
          state_nx   = DONE;
        end else begin
          addr_nx  = rom_address + 8'd1;
          state_nx = FETCH;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rom_address <= '0;
      cnt         <= '0;
      overrun     <= 1'b0;
    end else begin
      state       <= state_nx;
      rom_address <= addr_nx;
      cnt         <= cnt_nx;
      overrun     <= overrun_nx;
    end
  end

  assign busy = (state != IDLE) && (state != DONE);
  assign done = (state == DONE);

endmodule
